// File: rtl/axis_demux_pkg.sv
// Shared types and helpers for the AXI4-Stream N-port demultiplexer.
// Frame-state encoding, select-width helper and default counter width.
package axis_demux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_e;

    localparam int CNT_WIDTH_DEFAULT = 16;

    function automatic int sel_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/axis_demux_out_reg.sv
// Single-entry valid/ready output register for one demux channel.
// Loads on 'load', clears valid when drained without a concurrent load.
module axis_demux_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering. The payload is
    // reset as well because downstream logic expects all-zero fields after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_demux_n.sv
// M_COUNT-port AXI4-Stream demultiplexer, route chosen per frame (sel or tdest).
// Optional per-channel frame / drop counters when AXIS_DEMUX_STATS_EN is defined.
module axis_demux_n
    import axis_demux_pkg::*;
#(
    parameter int M_COUNT     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter bit ID_ENABLE   = 1'b0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = 8,
    parameter bit USER_ENABLE = 1'b1,
    parameter int USER_WIDTH  = 1,
    parameter bit TDEST_ROUTE = 1'b0,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEFAULT,
    localparam int SEL_WIDTH  = sel_width(M_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [ID_WIDTH-1:0]           s_axis_tid,
    input  logic [DEST_WIDTH-1:0]         s_axis_tdest,
    input  logic [USER_WIDTH-1:0]         s_axis_tuser,

    output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [M_COUNT-1:0]            m_axis_tvalid,
    input  logic [M_COUNT-1:0]            m_axis_tready,
    output logic [M_COUNT-1:0]            m_axis_tlast,
    output logic [M_COUNT*ID_WIDTH-1:0]   m_axis_tid,
    output logic [M_COUNT*DEST_WIDTH-1:0] m_axis_tdest,
    output logic [M_COUNT*USER_WIDTH-1:0] m_axis_tuser,

    input  logic                          enable,
    input  logic                          drop,
    input  logic [SEL_WIDTH-1:0]          sel
`ifdef AXIS_DEMUX_STATS_EN
    ,
    output logic [M_COUNT*CNT_WIDTH-1:0]  stat_frames,
    output logic [CNT_WIDTH-1:0]          stat_drops
`endif
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ROUTE = ROUTE;
    localparam logic [1:0] S_DROP  = DROP;

    localparam int PAYLOAD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    if (M_COUNT < 2 || M_COUNT > 16 || CNT_WIDTH < 1) begin : g_param_check
        $error("axis_demux_n: M_COUNT must be 2..16 and CNT_WIDTH at least 1");
    end

    logic [1:0]               state;
    logic [SEL_WIDTH-1:0]     route_ch;
    logic [SEL_WIDTH-1:0]     target;
    logic [SEL_WIDTH-1:0]     cur_ch;
    logic                     in_range;
    logic                     dropping;
    logic                     accept;
    logic [M_COUNT-1:0]       ch_hit;
    logic [M_COUNT-1:0]       ch_free;
    logic [M_COUNT-1:0]       load;

    logic [KEEP_WIDTH-1:0]    keep_in;
    logic [ID_WIDTH-1:0]      id_in;
    logic [USER_WIDTH-1:0]    user_in;
    logic [PAYLOAD_WIDTH-1:0] payload_in;
    logic                     unused_in;

    if (TDEST_ROUTE) begin : g_route_tdest
        assign target = s_axis_tdest[SEL_WIDTH-1:0];
    end else begin : g_route_sel
        assign target = sel;
    end

    // Non-power-of-two channel counts leave select codes with no channel behind them.
    assign in_range = ({1'b0, target} < (SEL_WIDTH + 1)'(M_COUNT));
    assign dropping = (state == S_DROP) || ((state == S_IDLE) && (drop || !in_range));
    assign cur_ch   = (state == S_IDLE) ? target : route_ch;

    assign s_axis_tready = enable && (dropping || |(ch_hit & ch_free));
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign keep_in    = KEEP_ENABLE ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
    assign id_in      = ID_ENABLE   ? s_axis_tid   : '0;
    assign user_in    = USER_ENABLE ? s_axis_tuser : '0;
    assign payload_in = {s_axis_tdata, keep_in, s_axis_tlast, id_in, s_axis_tdest, user_in};
    assign unused_in  = ^{s_axis_tkeep, s_axis_tid, s_axis_tuser, sel, s_axis_tdest};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            route_ch <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && !s_axis_tlast) begin
                        state    <= dropping ? S_DROP : S_ROUTE;
                        route_ch <= target;
                    end
                end
                S_ROUTE, S_DROP: begin
                    if (accept && s_axis_tlast) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < M_COUNT; k++) begin : g_ch
        logic [PAYLOAD_WIDTH-1:0] payload_out;

        assign ch_hit[k]  = (cur_ch == SEL_WIDTH'(k));
        assign ch_free[k] = !m_axis_tvalid[k] || m_axis_tready[k];
        assign load[k]    = accept && !dropping && ch_hit[k];

        axis_demux_out_reg #(
            .WIDTH (PAYLOAD_WIDTH)
        ) u_out_reg (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .in_data   (payload_in),
            .out_ready (m_axis_tready[k]),
            .out_data  (payload_out),
            .out_valid (m_axis_tvalid[k])
        );

        assign {m_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH],
                m_axis_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH],
                m_axis_tlast[k],
                m_axis_tid[k*ID_WIDTH +: ID_WIDTH],
                m_axis_tdest[k*DEST_WIDTH +: DEST_WIDTH],
                m_axis_tuser[k*USER_WIDTH +: USER_WIDTH]} = payload_out;
    end

`ifdef AXIS_DEMUX_STATS_EN
    logic [CNT_WIDTH-1:0] frame_cnt [M_COUNT];
    logic [CNT_WIDTH-1:0] drop_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < M_COUNT; k++) begin
                frame_cnt[k] <= '0;
            end
            drop_cnt <= '0;
        end else begin
            for (int k = 0; k < M_COUNT; k++) begin
                if (load[k] && s_axis_tlast) begin
                    frame_cnt[k] <= frame_cnt[k] + CNT_WIDTH'(1);
                end
            end
            if (accept && dropping && s_axis_tlast) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

    for (genvar k = 0; k < M_COUNT; k++) begin : g_stat
        assign stat_frames[k*CNT_WIDTH +: CNT_WIDTH] = frame_cnt[k];
    end
    assign stat_drops = drop_cnt;
`endif

endmodule

// File: tb/tb_axis_demux_n.sv
// Self-checking bench for axis_demux_n: a 4-port sel-routed instance and a
// 3-port tdest-routed instance share one ingress stream, checked against a frame-level model.
module tb_axis_demux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tvalid, s_tlast;
    logic [7:0]  s_tid, s_tdest;
    logic        s_tuser;
    logic        enable, drop;
    logic [1:0]  sel;

    logic        s0_tready, s1_tready;
    logic [127:0] m0_tdata;  logic [15:0] m0_tkeep; logic [3:0] m0_tvalid, m0_tready, m0_tlast, m0_tuser;
    logic [31:0]  m0_tid, m0_tdest;
    logic [95:0]  m1_tdata;  logic [11:0] m1_tkeep; logic [2:0] m1_tvalid, m1_tready, m1_tlast, m1_tuser;
    logic [23:0]  m1_tid, m1_tdest;
`ifdef AXIS_DEMUX_STATS_EN
    logic [63:0] stat_frames0; logic [15:0] stat_drops0;
    logic [47:0] stat_frames1; logic [15:0] stat_drops1;
`endif

    axis_demux_n #(.M_COUNT(4), .TDEST_ROUTE(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid), .s_axis_tready(s0_tready),
        .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m0_tdata), .m_axis_tkeep(m0_tkeep), .m_axis_tvalid(m0_tvalid), .m_axis_tready(m0_tready),
        .m_axis_tlast(m0_tlast), .m_axis_tid(m0_tid), .m_axis_tdest(m0_tdest), .m_axis_tuser(m0_tuser),
        .enable(enable), .drop(drop), .sel(sel)
`ifdef AXIS_DEMUX_STATS_EN
        , .stat_frames(stat_frames0), .stat_drops(stat_drops0)
`endif
    );

    axis_demux_n #(.M_COUNT(3), .TDEST_ROUTE(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid), .s_axis_tready(s1_tready),
        .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
        .m_axis_tlast(m1_tlast), .m_axis_tid(m1_tid), .m_axis_tdest(m1_tdest), .m_axis_tuser(m1_tuser),
        .enable(enable), .drop(drop), .sel(sel)
`ifdef AXIS_DEMUX_STATS_EN
        , .stat_frames(stat_frames1), .stat_drops(stat_drops1)
`endif
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [7:0]  dest;
        logic        user;
    } beat_t;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what each channel should be presenting, plus frame routing.
    beat_t hold     [2][4];
    bit    hold_v   [2][4];
    bit    in_frame [2];
    bit    fdrop    [2];
    int    fch      [2];
    int    frames_m [2][4];
    int    drops_m  [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int mc(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic logic dvalid(input int i, input int k);
        return (i == 0) ? m0_tvalid[k] : m1_tvalid[k];
    endfunction

    function automatic logic dready(input int i, input int k);
        return (i == 0) ? m0_tready[k] : m1_tready[k];
    endfunction

    function automatic logic dsready(input int i);
        return (i == 0) ? s0_tready : s1_tready;
    endfunction

    function automatic beat_t dbeat(input int i, input int k);
        beat_t b;
        if (i == 0) begin
            b.data = m0_tdata[k*32 +: 32]; b.keep = m0_tkeep[k*4 +: 4]; b.last = m0_tlast[k];
            b.dest = m0_tdest[k*8 +: 8];   b.user = m0_tuser[k];
        end else begin
            b.data = m1_tdata[k*32 +: 32]; b.keep = m1_tkeep[k*4 +: 4]; b.last = m1_tlast[k];
            b.dest = m1_tdest[k*8 +: 8];   b.user = m1_tuser[k];
        end
        return b;
    endfunction

`ifdef AXIS_DEMUX_STATS_EN
    function automatic logic [15:0] dframes(input int i, input int k);
        return (i == 0) ? stat_frames0[k*16 +: 16] : stat_frames1[k*16 +: 16];
    endfunction
    function automatic logic [15:0] ddrops(input int i);
        return (i == 0) ? stat_drops0 : stat_drops1;
    endfunction
`endif

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) begin
            in_frame[i] = 1'b0;
            fdrop[i]    = 1'b0;
            fch[i]      = 0;
            drops_m[i]  = 0;
            for (int k = 0; k < 4; k++) begin
                hold_v[i][k]   = 1'b0;
                hold[i][k]     = '0;
                frames_m[i][k] = 0;
            end
        end
    endfunction

    // One clock: check DUT outputs against the model, advance the model, cross the edge.
    // Called and returns at a falling edge; inputs are changed by the caller between steps.
    task automatic step(output bit acc0);
        bit    rdy, dr, acc;
        int    tgt, ch;
        beat_t b;
        #1;
        b.data = s_tdata; b.keep = s_tkeep; b.last = s_tlast; b.dest = s_tdest; b.user = s_tuser;
        acc0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!in_frame[i]) begin
                tgt = (i == 1) ? int'(s_tdest[1:0]) : int'(sel);
                dr  = drop || (tgt >= mc(i));
                ch  = tgt;
            end else begin
                dr = fdrop[i];
                ch = fch[i];
            end
            rdy = enable && (dr || !hold_v[i][ch] || dready(i, ch));
            check($sformatf("s_tready dut%0d", i), 64'(dsready(i)), 64'(rdy));
            for (int k = 0; k < mc(i); k++) begin
                check($sformatf("tvalid dut%0d ch%0d", i, k), 64'(dvalid(i, k)), 64'(hold_v[i][k]));
                if (hold_v[i][k])
                    check($sformatf("payload dut%0d ch%0d", i, k), 64'(dbeat(i, k)), 64'(hold[i][k]));
`ifdef AXIS_DEMUX_STATS_EN
                check($sformatf("stat_frames dut%0d ch%0d", i, k), 64'(dframes(i, k)), 64'(frames_m[i][k] % 65536));
`endif
            end
`ifdef AXIS_DEMUX_STATS_EN
            check($sformatf("stat_drops dut%0d", i), 64'(ddrops(i)), 64'(drops_m[i] % 65536));
`endif
            acc = s_tvalid && rdy;
            if (i == 0) acc0 = acc;
            for (int k = 0; k < mc(i); k++) begin
                if (acc && !dr && ch == k) begin
                    hold[i][k]   = b;
                    hold_v[i][k] = 1'b1;
                    if (s_tlast) frames_m[i][k]++;
                end else if (hold_v[i][k] && dready(i, k)) begin
                    hold_v[i][k] = 1'b0;
                end
            end
            if (acc) begin
                if (dr && s_tlast) drops_m[i]++;
                if (!in_frame[i] && !s_tlast) begin
                    in_frame[i] = 1'b1;
                    fdrop[i]    = dr;
                    fch[i]      = ch;
                end else if (in_frame[i] && s_tlast) begin
                    in_frame[i] = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d, input bit last);
        bit a;
        int tries;
        tries    = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        s_tkeep  = 4'($urandom);
        s_tuser  = 1'($urandom);
        do begin
            step(a);
            tries++;
        end while (!a && tries < 20);
        check("accept_within_bound", 64'(a), 64'd1);
        s_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit a;
        int beats;
        bit pat [10];

        rst_n = 1'b0; enable = 1'b0; drop = 1'b0; sel = 2'd0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
        s_tid = 8'h5A; s_tdest = 8'd0; s_tuser = 1'b0;
        m0_tready = '0; m1_tready = '0;
        @(negedge clk);
        do_reset();

        // Reset state, with ingress disabled
        #1;
        check("reset m0_tvalid", 64'(m0_tvalid), 64'd0);
        check("reset m1_tvalid", 64'(m1_tvalid), 64'd0);
        check("reset m0_tdata", m0_tdata[63:0], 64'd0);
        check("reset m0_tkeep", 64'(m0_tkeep), 64'd0);
        check("reset m0_tdest", 64'(m0_tdest), 64'd0);
        check("reset m0_tid", 64'(m0_tid), 64'd0);
        check("enable0 s0_tready", 64'(s0_tready), 64'd0);
        step(a);

        enable = 1'b1; m0_tready = 4'hF; m1_tready = 3'h7;
        #1;
        check("enable1 s0_tready", 64'(s0_tready), 64'd1);

        // Three-beat frame to channel 2; sel moves to 0 mid-frame and must be ignored
        s_tdest = 8'd1;
        sel = 2'd2; send(32'hA0, 1'b0);
        sel = 2'd0; send(32'hA1, 1'b0);
        send(32'hA2, 1'b1);
        step(a);
        send(32'hB0, 1'b0);
        sel = 2'd3; send(32'hB1, 1'b1);
        step(a);

        // Dropped four-beat frame
        sel = 2'd1; drop = 1'b1; send(32'hC0, 1'b0);
        drop = 1'b0;
        send(32'hC1, 1'b0); send(32'hC2, 1'b0); send(32'hC3, 1'b1);
        step(a);

        // tdest out of range for the 3-port instance, then in range
        s_tdest = 8'd3; send(32'hD0, 1'b0); send(32'hD1, 1'b1);
        s_tdest = 8'd1; send(32'hE0, 1'b1);
        step(a);

        // Five-beat frame on channel 1 with its ready toggling
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        sel = 2'd1; beats = 0;
        for (int c = 0; c < 30 && beats < 5; c++) begin
            m0_tready[1] = (c < 10) ? pat[c] : 1'b1;
            s_tvalid = 1'b1;
            s_tdata  = 32'hF0 + 32'(beats);
            s_tlast  = (beats == 4);
            step(a);
            if (a) beats++;
        end
        check("stall_frame_beats", 64'(beats), 64'd5);
        s_tvalid = 1'b0; m0_tready = 4'hF;
        step(a); step(a);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            s_tvalid  = ($urandom_range(0, 3) != 0);
            s_tdata   = $urandom;
            s_tkeep   = 4'($urandom);
            s_tuser   = 1'($urandom);
            s_tlast   = ($urandom_range(0, 3) == 0);
            s_tdest   = 8'($urandom);
            sel       = 2'($urandom);
            drop      = ($urandom_range(0, 7) == 0);
            enable    = ($urandom_range(0, 7) != 0);
            m0_tready = 4'($urandom);
            m1_tready = 3'($urandom);
            step(a);
        end

        // Reset while channel 0 holds a beat mid-frame
        s_tvalid = 1'b0; drop = 1'b0; enable = 1'b1; m0_tready = 4'hF; m1_tready = 3'h7;
        step(a); step(a);
        m0_tready = 4'h0; m1_tready = 3'h0; sel = 2'd0; s_tdest = 8'd0;
        send(32'h1234_0000, 1'b0);
        step(a);
        do_reset();
        #1;
        check("midreset m0_tvalid", 64'(m0_tvalid), 64'd0);
        m0_tready = 4'hF; m1_tready = 3'h7; sel = 2'd3; s_tdest = 8'd2;
        send(32'h1234_0001, 1'b1);
        step(a); step(a);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
